// File: rtl/fetch_buffer_unit.sv
// Fetch front end: sequential PC generation, credit-limited imem requests and a DEPTH-entry
// instruction FIFO towards Decode. Optional same-cycle bypass guarded by FETCH_BYPASS_EN.
module fetch_buffer_unit #(
  parameter int                  PC_SIZE         = 32,
  parameter int                  INSTR_SIZE      = 32,
  parameter int                  DEPTH           = 4,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter logic [PC_SIZE-1:0]  RESET_PC        = {PC_SIZE{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [PC_SIZE-1:0]         redirect_pc,
  output logic                       imem_req,
  output logic [PC_SIZE-1:0]         imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [INSTR_SIZE-1:0]      imem_rdata,
  output logic                       dec_valid,
  output logic [INSTR_SIZE-1:0]      dec_instr,
  output logic [PC_SIZE-1:0]         dec_pc,
  input  logic                       dec_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = CNT_W + OUT_W + 1;

  logic [INSTR_SIZE-1:0] instr_mem_r [DEPTH];
  logic [PC_SIZE-1:0]    pc_mem_r    [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [OUT_W-1:0]      outstanding_r;
  logic [OUT_W-1:0]      drop_cnt_r;
  logic [PC_SIZE-1:0]    fetch_pc_r;
  logic [PC_SIZE-1:0]    resp_pc_r;

  logic [OUT_W-1:0]      live_s;
  logic [SUM_W-1:0]      credit_sum_s;
  logic                  empty_s;
  logic                  req_s;
  logic                  gnt_s;
  logic                  rsp_live_s;
  logic                  bypass_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  unused_s;

  assign unused_s = ^redirect_pc[1:0];

  // Zero-latency path only exists when the FIFO is empty and the response is not stale.
`ifdef FETCH_BYPASS_EN
  assign bypass_s = empty_s & rsp_live_s;
`else
  assign bypass_s = 1'b0;
`endif

  // Credit check counts buffered entries plus live (non-dropped) in-flight responses.
  always_comb begin
    live_s       = outstanding_r - drop_cnt_r;
    credit_sum_s = SUM_W'(count_r) + SUM_W'(live_s);
    empty_s      = (count_r == {CNT_W{1'b0}});
    req_s        = !rst && !redirect_valid && (outstanding_r < OUT_W'(MAX_OUTSTANDING)) &&
                   (credit_sum_s < SUM_W'(DEPTH));
    gnt_s        = req_s & imem_gnt;
    rsp_live_s   = imem_rvalid & !redirect_valid & (drop_cnt_r == {OUT_W{1'b0}});
    pop_s        = !redirect_valid & !empty_s & dec_ready;
    push_s       = rsp_live_s & !(bypass_s & dec_ready);
  end

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;
  assign occupancy = count_r;
  assign dec_valid = !rst & !redirect_valid & (!empty_s | bypass_s);
  assign dec_instr = bypass_s ? imem_rdata : instr_mem_r[rd_ptr_r];
  assign dec_pc    = bypass_s ? resp_pc_r  : pc_mem_r[rd_ptr_r];

  // Control state: redirect overrides grant, response and pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      outstanding_r <= {OUT_W{1'b0}};
      drop_cnt_r    <= {OUT_W{1'b0}};
    end else if (redirect_valid) begin
      fetch_pc_r    <= {redirect_pc[PC_SIZE-1:2], 2'b00};
      resp_pc_r     <= {redirect_pc[PC_SIZE-1:2], 2'b00};
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      outstanding_r <= outstanding_r - OUT_W'(imem_rvalid);
      drop_cnt_r    <= outstanding_r - OUT_W'(imem_rvalid);
    end else begin
      if (gnt_s) begin
        fetch_pc_r <= fetch_pc_r + PC_SIZE'(4);
      end
      outstanding_r <= outstanding_r + OUT_W'(gnt_s) - OUT_W'(imem_rvalid);
      if (imem_rvalid && (drop_cnt_r != {OUT_W{1'b0}})) begin
        drop_cnt_r <= drop_cnt_r - OUT_W'(1);
      end
      if (rsp_live_s) begin
        resp_pc_r <= resp_pc_r + PC_SIZE'(4);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; never written while full thanks to the request credit check.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]    <= resp_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Self-checking bench for fetch_buffer_unit: directed scenarios plus random traffic checked
// against a queue-based model of the buffer and in-flight requests.
module tb_fetch_buffer_unit;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic [2:0]  occupancy;

  fetch_buffer_unit #(
    .PC_SIZE(32), .INSTR_SIZE(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
  } req_t;

  req_t        inflight[$];
  logic [31:0] buf_pc[$];
  logic [31:0] buf_instr[$];
  logic [31:0] fetch_pc_m;
  int          chk_cnt = 0;
  int          err_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, compare against model, advance model for next posedge.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic g,
                      input logic rv, input logic rdy);
    logic rv_eff;
    logic exp_req;
    logic exp_dv;
    int   live;
    req_t e;
    @(negedge clk);
    rv_eff         = rv && (inflight.size() > 0);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = rv_eff;
    imem_rdata     = rv_eff ? mem_word(inflight[0].addr) : $urandom;
    dec_ready      = rdy;
    #1;
    live = 0;
    foreach (inflight[i]) if (!inflight[i].stale) live++;
    exp_req = !redir && (inflight.size() < MAXO) && ((buf_pc.size() + live) < DEPTH);
    exp_dv  = !redir && (buf_pc.size() > 0);
    check_val("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check_val("imem_addr", 64'(imem_addr), 64'(fetch_pc_m));
    check_val("dec_valid", 64'(dec_valid), 64'(exp_dv));
    if (exp_dv) begin
      check_val("dec_pc", 64'(dec_pc), 64'(buf_pc[0]));
      check_val("dec_instr", 64'(dec_instr), 64'(buf_instr[0]));
    end
    check_val("occupancy", 64'(occupancy), 64'(buf_pc.size()));
    if (redir) begin
      buf_pc.delete();
      buf_instr.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      if (rv_eff) void'(inflight.pop_front());
      fetch_pc_m = {rpc[31:2], 2'b00};
    end else begin
      if (exp_dv && rdy) begin
        void'(buf_pc.pop_front());
        void'(buf_instr.pop_front());
      end
      if (rv_eff) begin
        e = inflight.pop_front();
        if (!e.stale) begin
          buf_pc.push_back(e.addr);
          buf_instr.push_back(mem_word(e.addr));
        end
      end
      if (exp_req && g) begin
        inflight.push_back('{addr: fetch_pc_m, stale: 1'b0});
        fetch_pc_m = fetch_pc_m + 32'd4;
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; dec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_val("rst_imem_req", 64'(imem_req), 64'd0);
      check_val("rst_dec_valid", 64'(dec_valid), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    inflight.delete(); buf_pc.delete(); buf_instr.delete();
    fetch_pc_m = 32'h100;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Streaming from 0 with immediate responses and an always-ready decoder.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Backpressure: buffer fills, then drains in order.
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_val("bp_full", 64'(occupancy), 64'(DEPTH));
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Redirect with requests in flight and a buffered entry; response and pop in same cycle.
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h203, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
